// File: rtl/dvp_rgb_capture_pkg.sv
// dvp_capture_pkg: shared types and helpers for the DVP RGB capture front end.
//   cap_state_t    - capture FSM encoding (WAIT=0, SKIP=1, RUN=2), visible on cap_state
//   COORD_W        - width of pixel / line counters and crop-relative coordinates
//   rgb565_to_888  - RGB565 to RGB888 expansion, mode 1 = MSB replication, 0 = zero pad
package dvp_capture_pkg;

  typedef enum logic [1:0] {
    CAP_WAIT = 2'd0,
    CAP_SKIP = 2'd1,
    CAP_RUN  = 2'd2
  } cap_state_t;

  localparam int COORD_W = 12;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [COORD_W:0]   coord_ext_t;

  localparam coord_t COORD_ZERO = 12'd0;
  localparam coord_t COORD_ONE  = 12'd1;
  localparam coord_t COORD_MAX  = 12'hFFF;

  function automatic logic [23:0] rgb565_to_888(input logic [15:0] pix, input logic mode);
    logic [4:0] r5;
    logic [5:0] g6;
    logic [4:0] b5;
    r5 = pix[15:11];
    g6 = pix[10:5];
    b5 = pix[4:0];
    if (mode) begin
      return {r5, r5[4:2], g6, g6[5:4], b5, b5[4:2]};
    end else begin
      return {r5, 3'b000, g6, 2'b00, b5, 3'b000};
    end
  endfunction

endpackage

// File: rtl/dvp_rgb_capture_expand.sv
// rgb565_expand: registered RGB565 -> RGB888 expansion stage.
//   clk, rst_n      - pixel clock, async active-low reset
//   in_valid        - pix carries a pixel to present this cycle
//   pix             - RGB565 pixel
//   red/green/blue  - RGB888 result; holds its last value while in_valid is low
module rgb565_expand
  import dvp_capture_pkg::*;
#(
  parameter int EXPAND_MODE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [15:0] pix,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue
);

  localparam logic MODE = (EXPAND_MODE != 0);

  logic [23:0] rgb;

  assign rgb = rgb565_to_888(pix, MODE);

  // Capture the expanded colour only for valid pixels so the outputs hold between them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      red   <= 8'd0;
      green <= 8'd0;
      blue  <= 8'd0;
    end else if (in_valid) begin
      red   <= rgb[23:16];
      green <= rgb[15:8];
      blue  <= rgb[7:0];
    end
  end

endmodule

// File: rtl/dvp_rgb_capture.sv
// dvp_rgb_capture: DVP camera capture front end, entirely in the pclk domain.
// Pairs bus bytes into RGB565 pixels, drops start-up frames, crops a window and
// presents RGB888 pixels with crop-relative coordinates two cycles after the
// second byte of each pair is registered.
//   pclk, rst_n          - sensor pixel clock, async active-low reset
//   vsync, href, data    - sensor frame sync, line valid, 8-bit bus
//   enable               - capture enable, taken at each frame start
//   red/green/blue       - RGB888 pixel, held while data_valid is low
//   data_valid           - pixel inside the crop window of a captured frame
//   data_hs, data_vs     - href / vsync aligned with the pixel outputs
//   x_addr, y_addr       - crop-relative coordinates, held while data_valid is low
//   frame_done           - pulse with the last pixel of the crop window
//   cap_state            - capture FSM state (WAIT=0, SKIP=1, RUN=2)
module dvp_rgb_capture
  import dvp_capture_pkg::*;
#(
  parameter int IMAGE_WIDTH  = 1280,
  parameter int IMAGE_HEIGHT = 720,
  parameter int SKIP_FRAMES  = 10,
  parameter int CROP_X0      = 0,
  parameter int CROP_Y0      = 0,
  parameter int CROP_W       = 1280,
  parameter int CROP_H       = 720,
  parameter int EXPAND_MODE  = 1,
  parameter int BYTE_ORDER   = 0,
  parameter int VS_OUT_POL   = 0
) (
  input  logic               pclk,
  input  logic               rst_n,
  input  logic               vsync,
  input  logic               href,
  input  logic [7:0]         data,
  input  logic               enable,
  output logic [7:0]         red,
  output logic [7:0]         green,
  output logic [7:0]         blue,
  output logic               data_valid,
  output logic               data_hs,
  output logic               data_vs,
  output logic [COORD_W-1:0] x_addr,
  output logic [COORD_W-1:0] y_addr,
  output logic               frame_done,
  output logic [1:0]         cap_state
);

  if ((CROP_X0 + CROP_W > IMAGE_WIDTH) || (CROP_Y0 + CROP_H > IMAGE_HEIGHT) ||
      (SKIP_FRAMES < 0) || (SKIP_FRAMES > 255)) begin : g_bad_params
    $fatal(1, "dvp_rgb_capture: crop window outside image or SKIP_FRAMES out of range");
  end

  localparam logic [7:0] SKIP_N     = 8'(SKIP_FRAMES);
  localparam coord_ext_t X_LO       = coord_ext_t'(CROP_X0);
  localparam coord_ext_t Y_LO       = coord_ext_t'(CROP_Y0);
  localparam coord_ext_t X_SPAN     = coord_ext_t'(CROP_W);
  localparam coord_ext_t Y_SPAN     = coord_ext_t'(CROP_H);
  localparam coord_t     X_LAST     = coord_t'(CROP_W - 1);
  localparam coord_t     Y_LAST     = coord_t'(CROP_H - 1);
  localparam logic       VS_ACTIVE  = (VS_OUT_POL != 0);

  logic        vsync_q, href_q, vsync_d, href_d;
  logic [7:0]  data_q;
  cap_state_t  state;
  logic [7:0]  skip_cnt;
  logic        frame_en;
  logic        phase;
  logic [7:0]  first_byte;
  coord_t      x, y;

  logic        vs_rise, href_fall, pix_done, in_win, pix_ok;
  coord_ext_t  dx, dy;
  logic [15:0] pix_word;

  logic        vld_s1, done_s1;
  logic [15:0] pix_s1;
  coord_t      x_s1, y_s1;

  // Edge detection, pixel assembly and crop decision for the current byte.
  always_comb begin
    vs_rise   = vsync_q & ~vsync_d;
    href_fall = ~href_q & href_d;
    // A vsync rise aborts any pair in progress, so no pixel completes on it.
    pix_done  = href_q & phase & ~vs_rise;
    // Offsets below the origin wrap to >= 4097 in 13 bits, above any legal span.
    dx        = {1'b0, x} - X_LO;
    dy        = {1'b0, y} - Y_LO;
    in_win    = (dx < X_SPAN) && (dy < Y_SPAN);
    pix_ok    = pix_done && (state == CAP_RUN) && frame_en && in_win;
    if (BYTE_ORDER == 0) begin
      pix_word = {first_byte, data_q};
    end else begin
      pix_word = {data_q, first_byte};
    end
  end

  // Pin registers plus the second sync stage used for edges and output alignment.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      data_q  <= 8'd0;
      vsync_d <= 1'b0;
      href_d  <= 1'b0;
    end else begin
      vsync_q <= vsync;
      href_q  <= href;
      data_q  <= data;
      vsync_d <= vsync_q;
      href_d  <= href_q;
    end
  end

  // Start-up frame skipping and per-frame enable latch, both advanced on vsync rises.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= CAP_WAIT;
      skip_cnt <= 8'd0;
      frame_en <= 1'b0;
    end else if (vs_rise) begin
      case (state)
        CAP_WAIT: begin
          if (SKIP_N == 8'd0) begin
            state    <= CAP_RUN;
            frame_en <= enable;
          end else begin
            state    <= CAP_SKIP;
            skip_cnt <= 8'd1;
          end
        end
        CAP_SKIP: begin
          if (skip_cnt == SKIP_N) begin
            state    <= CAP_RUN;
            frame_en <= enable;
          end else begin
            skip_cnt <= skip_cnt + 8'd1;
          end
        end
        CAP_RUN: begin
          frame_en <= enable;
        end
        default: begin
          state    <= CAP_WAIT;
          skip_cnt <= 8'd0;
          frame_en <= 1'b0;
        end
      endcase
    end
  end

  // Byte pairing: phase 0 stores the first byte, phase 1 completes the pixel.
  // Clearing while href is low drops a dangling odd byte at the end of a line.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      phase      <= 1'b0;
      first_byte <= 8'd0;
    end else if (vs_rise || !href_q) begin
      phase      <= 1'b0;
    end else begin
      phase      <= ~phase;
      if (!phase) begin
        first_byte <= data_q;
      end
    end
  end

  // Saturating pixel / line counters; a vsync rise takes priority over a line end.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      x <= COORD_ZERO;
      y <= COORD_ZERO;
    end else if (vs_rise) begin
      x <= COORD_ZERO;
      y <= COORD_ZERO;
    end else if (href_fall) begin
      x <= COORD_ZERO;
      if (y != COORD_MAX) begin
        y <= y + COORD_ONE;
      end
    end else if (pix_done && (x != COORD_MAX)) begin
      x <= x + COORD_ONE;
    end
  end

  // First pipeline stage: latch the assembled pixel and its crop-relative position.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      vld_s1  <= 1'b0;
      done_s1 <= 1'b0;
      pix_s1  <= 16'd0;
      x_s1    <= COORD_ZERO;
      y_s1    <= COORD_ZERO;
    end else begin
      vld_s1  <= pix_ok;
      done_s1 <= pix_ok && (dx[COORD_W-1:0] == X_LAST) && (dy[COORD_W-1:0] == Y_LAST);
      if (pix_ok) begin
        pix_s1 <= pix_word;
        x_s1   <= dx[COORD_W-1:0];
        y_s1   <= dy[COORD_W-1:0];
      end
    end
  end

  // Output stage: qualifiers, coordinates and syncs aligned with the colour register.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      data_valid <= 1'b0;
      frame_done <= 1'b0;
      x_addr     <= COORD_ZERO;
      y_addr     <= COORD_ZERO;
      data_hs    <= 1'b0;
      data_vs    <= ~VS_ACTIVE;
    end else begin
      data_valid <= vld_s1;
      frame_done <= done_s1;
      if (vld_s1) begin
        x_addr <= x_s1;
        y_addr <= y_s1;
      end
      data_hs    <= href_d;
      data_vs    <= VS_ACTIVE ? vsync_d : ~vsync_d;
    end
  end

  assign cap_state = state;

  rgb565_expand #(
    .EXPAND_MODE(EXPAND_MODE)
  ) u_expand (
    .clk      (pclk),
    .rst_n    (rst_n),
    .in_valid (vld_s1),
    .pix      (pix_s1),
    .red      (red),
    .green    (green),
    .blue     (blue)
  );

endmodule

// File: tb/tb_dvp_rgb_capture.sv
// Directed bench for dvp_rgb_capture. Two instances share the sensor pins:
//   u_a: 8x4 image, SKIP_FRAMES=2, full crop, replicate expansion, active-low data_vs
//   u_b: 4x4 image, SKIP_FRAMES=0, crop (1,1) 2x2, zero-pad expansion, active-high data_vs
module tb_dvp_rgb_capture;

  typedef struct {
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic [11:0] x;
    logic [11:0] y;
    logic        done;
    logic        hs;
  } pix_t;

  logic        pclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vsync = 1'b0;
  logic        href = 1'b0;
  logic [7:0]  data = 8'd0;
  logic        enable = 1'b1;

  logic [7:0]  a_r, a_g, a_b, b_r, b_g, b_b;
  logic        a_valid, a_hs, a_vs, a_done, b_valid, b_hs, b_vs, b_done;
  logic [11:0] a_x, a_y, b_x, b_y;
  logic [1:0]  a_state, b_state;

  pix_t qa[$];
  pix_t qb[$];
  int   done_a = 0;
  int   done_b = 0;
  int   total = 0;
  int   bad = 0;

  always #5 pclk = ~pclk;

  dvp_rgb_capture #(
    .IMAGE_WIDTH(8), .IMAGE_HEIGHT(4), .SKIP_FRAMES(2), .CROP_X0(0), .CROP_Y0(0),
    .CROP_W(8), .CROP_H(4), .EXPAND_MODE(1), .BYTE_ORDER(0), .VS_OUT_POL(0)
  ) u_a (
    .pclk(pclk), .rst_n(rst_n), .vsync(vsync), .href(href), .data(data), .enable(enable),
    .red(a_r), .green(a_g), .blue(a_b), .data_valid(a_valid), .data_hs(a_hs), .data_vs(a_vs),
    .x_addr(a_x), .y_addr(a_y), .frame_done(a_done), .cap_state(a_state)
  );

  dvp_rgb_capture #(
    .IMAGE_WIDTH(4), .IMAGE_HEIGHT(4), .SKIP_FRAMES(0), .CROP_X0(1), .CROP_Y0(1),
    .CROP_W(2), .CROP_H(2), .EXPAND_MODE(0), .BYTE_ORDER(0), .VS_OUT_POL(1)
  ) u_b (
    .pclk(pclk), .rst_n(rst_n), .vsync(vsync), .href(href), .data(data), .enable(enable),
    .red(b_r), .green(b_g), .blue(b_b), .data_valid(b_valid), .data_hs(b_hs), .data_vs(b_vs),
    .x_addr(b_x), .y_addr(b_y), .frame_done(b_done), .cap_state(b_state)
  );

  // Record every valid output pixel, sampled away from the active edge.
  always @(negedge pclk) begin
    if (a_valid === 1'b1) qa.push_back('{a_r, a_g, a_b, a_x, a_y, a_done, a_hs});
    if (b_valid === 1'b1) qb.push_back('{b_r, b_g, b_b, b_x, b_y, b_done, b_hs});
    if (a_done === 1'b1) done_a++;
    if (b_done === 1'b1) done_b++;
  end

  task automatic cyc();
    @(negedge pclk);
  endtask

  task automatic clear_logs();
    qa.delete();
    qb.delete();
    done_a = 0;
    done_b = 0;
  endtask

  task automatic frame_start();
    vsync = 1'b1;
    repeat (3) cyc();
    vsync = 1'b0;
    repeat (3) cyc();
  endtask

  task automatic drive_line(input int nbytes, input logic [7:0] b0, input logic [7:0] b1);
    for (int i = 0; i < nbytes; i++) begin
      href = 1'b1;
      data = (i % 2 == 0) ? b0 : b1;
      cyc();
    end
    href = 1'b0;
    data = 8'd0;
    repeat (4) cyc();
  endtask

  task automatic drive_frame(input int nlines, input int nbytes, input logic [7:0] b0,
                             input logic [7:0] b1, input bit en_mid);
    frame_start();
    for (int l = 0; l < nlines; l++) begin
      drive_line(nbytes, b0, b1);
      if (en_mid && l == 0) enable = 1'b1;
    end
    repeat (6) cyc();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) cyc();
    total++; if (a_state !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", a_state); end
    total++; if (a_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", a_valid); end
    total++; if ({a_r, a_g, a_b} !== 24'd0) begin bad++; $display("FAIL reset_rgb: got %h want 000000", {a_r, a_g, a_b}); end
    total++; if ({a_x, a_y, a_hs, a_done} !== 26'd0) begin bad++; $display("FAIL reset_misc: got %h want 0", {a_x, a_y, a_hs, a_done}); end
    total++; if (a_vs !== 1'b1) begin bad++; $display("FAIL reset_vs_lowpol: got %b want 1", a_vs); end
    total++; if (b_vs !== 1'b0) begin bad++; $display("FAIL reset_vs_highpol: got %b want 0", b_vs); end
    rst_n = 1'b1;
    repeat (2) cyc();
  endtask

  task automatic test_skip();
    clear_logs();
    drive_frame(2, 8, 8'hF8, 8'h1F, 1'b0);
    total++; if (a_state !== 2'd1) begin bad++; $display("FAIL skip_state_f1: got %0d want 1", a_state); end
    total++; if (qa.size() != 0) begin bad++; $display("FAIL skip_valid_f1: got %0d want 0", qa.size()); end
    clear_logs();
    drive_frame(2, 8, 8'hF8, 8'h1F, 1'b0);
    total++; if (a_state !== 2'd1) begin bad++; $display("FAIL skip_state_f2: got %0d want 1", a_state); end
    total++; if (qa.size() != 0) begin bad++; $display("FAIL skip_valid_f2: got %0d want 0", qa.size()); end
    clear_logs();
    drive_frame(2, 8, 8'hF8, 8'h1F, 1'b0);
    total++; if (a_state !== 2'd2) begin bad++; $display("FAIL skip_state_f3: got %0d want 2", a_state); end
    total++; if (qa.size() != 8) begin bad++; $display("FAIL skip_valid_f3: got %0d want 8", qa.size()); end
    for (int i = 0; i < qa.size() && i < 8; i++) begin
      total++;
      if (qa[i].x !== 12'(i % 4) || qa[i].y !== 12'(i / 4) || qa[i].hs !== 1'b1) begin
        bad++; $display("FAIL skip_coord[%0d]: got x=%0d y=%0d hs=%b want x=%0d y=%0d hs=1", i, qa[i].x, qa[i].y, qa[i].hs, i % 4, i / 4);
      end
      total++;
      if ({qa[i].r, qa[i].g, qa[i].b} !== 24'hFF00FF) begin
        bad++; $display("FAIL skip_rgb_rep[%0d]: got %h want ff00ff", i, {qa[i].r, qa[i].g, qa[i].b});
      end
    end
  endtask

  task automatic test_crop();
    logic [11:0] ex[4];
    logic [11:0] ey[4];
    ex = '{12'd0, 12'd1, 12'd0, 12'd1};
    ey = '{12'd0, 12'd0, 12'd1, 12'd1};
    clear_logs();
    drive_frame(4, 8, 8'hF8, 8'h1F, 1'b0);
    total++; if (qb.size() != 4) begin bad++; $display("FAIL crop_count: got %0d want 4", qb.size()); end
    total++; if (done_b != 1) begin bad++; $display("FAIL crop_done_count: got %0d want 1", done_b); end
    total++; if (qa.size() != 16) begin bad++; $display("FAIL full_count: got %0d want 16", qa.size()); end
    for (int i = 0; i < qb.size() && i < 4; i++) begin
      total++;
      if (qb[i].x !== ex[i] || qb[i].y !== ey[i] || qb[i].done !== (i == 3)) begin
        bad++; $display("FAIL crop_pix[%0d]: got (%0d,%0d) done=%b want (%0d,%0d) done=%b", i, qb[i].x, qb[i].y, qb[i].done, ex[i], ey[i], i == 3);
      end
      total++;
      if ({qb[i].r, qb[i].g, qb[i].b} !== 24'hF800F8) begin
        bad++; $display("FAIL crop_rgb_zero[%0d]: got %h want f800f8", i, {qb[i].r, qb[i].g, qb[i].b});
      end
    end
  endtask

  task automatic test_colour();
    clear_logs();
    drive_frame(2, 8, 8'h84, 8'h10, 1'b0);
    total++; if (qa.size() != 8) begin bad++; $display("FAIL colour_count: got %0d want 8", qa.size()); end
    if (qa.size() > 0) begin
      total++; if ({qa[0].r, qa[0].g, qa[0].b} !== 24'h848284) begin bad++; $display("FAIL colour_rep_8410: got %h want 848284", {qa[0].r, qa[0].g, qa[0].b}); end
    end
    total++; if (qb.size() != 2) begin bad++; $display("FAIL colour_b_count: got %0d want 2", qb.size()); end
    if (qb.size() > 0) begin
      total++; if ({qb[0].r, qb[0].g, qb[0].b} !== 24'h808080) begin bad++; $display("FAIL colour_zero_8410: got %h want 808080", {qb[0].r, qb[0].g, qb[0].b}); end
    end
    total++; if ({a_r, a_g, a_b} !== 24'h848284) begin bad++; $display("FAIL colour_hold: got %h want 848284", {a_r, a_g, a_b}); end
    total++; if (a_x !== 12'd3 || a_y !== 12'd1) begin bad++; $display("FAIL addr_hold: got (%0d,%0d) want (3,1)", a_x, a_y); end
  endtask

  task automatic test_enable();
    clear_logs();
    enable = 1'b0;
    drive_frame(2, 8, 8'hF8, 8'h1F, 1'b1);
    total++; if (qa.size() != 0) begin bad++; $display("FAIL enable_off_a: got %0d want 0", qa.size()); end
    total++; if (qb.size() != 0) begin bad++; $display("FAIL enable_off_b: got %0d want 0", qb.size()); end
    clear_logs();
    drive_frame(2, 8, 8'hF8, 8'h1F, 1'b0);
    total++; if (qa.size() != 8) begin bad++; $display("FAIL enable_next_a: got %0d want 8", qa.size()); end
    total++; if (qb.size() != 2) begin bad++; $display("FAIL enable_next_b: got %0d want 2", qb.size()); end
  endtask

  task automatic test_odd_bytes();
    clear_logs();
    drive_frame(2, 9, 8'hF8, 8'h1F, 1'b0);
    total++; if (qa.size() != 8) begin bad++; $display("FAIL odd_count: got %0d want 8", qa.size()); end
    for (int i = 0; i < qa.size() && i < 8; i++) begin
      total++;
      if (qa[i].x !== 12'(i % 4) || qa[i].y !== 12'(i / 4) || {qa[i].r, qa[i].g, qa[i].b} !== 24'hFF00FF) begin
        bad++; $display("FAIL odd_pix[%0d]: got (%0d,%0d) %h want (%0d,%0d) ff00ff", i, qa[i].x, qa[i].y, {qa[i].r, qa[i].g, qa[i].b}, i % 4, i / 4);
      end
    end
  endtask

  task automatic test_abort_and_reset();
    clear_logs();
    frame_start();
    drive_line(8, 8'hF8, 8'h1F);
    // Second line cut after two pixels by a vsync rise coinciding with the href fall.
    for (int i = 0; i < 4; i++) begin
      href = 1'b1;
      data = (i % 2 == 0) ? 8'hF8 : 8'h1F;
      cyc();
    end
    href = 1'b0;
    vsync = 1'b1;
    data = 8'd0;
    repeat (3) cyc();
    vsync = 1'b0;
    repeat (3) cyc();
    drive_line(8, 8'hF8, 8'h1F);
    drive_line(8, 8'hF8, 8'h1F);
    repeat (6) cyc();
    total++; if (done_b != 0) begin bad++; $display("FAIL abort_done: got %0d want 0", done_b); end
    total++; if (qb.size() != 3) begin bad++; $display("FAIL abort_count: got %0d want 3", qb.size()); end
    if (qb.size() == 3) begin
      total++; if (qb[2].y !== 12'd0 || qb[2].x !== 12'd1) begin bad++; $display("FAIL abort_y_clear: got (%0d,%0d) want (1,0)", qb[2].x, qb[2].y); end
    end
    // Reset in the middle of the next frame's second line.
    frame_start();
    drive_line(8, 8'hF8, 8'h1F);
    for (int i = 0; i < 3; i++) begin
      href = 1'b1;
      data = (i % 2 == 0) ? 8'hF8 : 8'h1F;
      cyc();
    end
    #1 rst_n = 1'b0;
    #1;
    total++; if (a_state !== 2'd0 || b_state !== 2'd0) begin bad++; $display("FAIL rst_mid_state: got a=%0d b=%0d want 0", a_state, b_state); end
    total++; if ({a_valid, a_r, a_g, a_b, a_x, a_y, a_hs} !== 50'd0) begin bad++; $display("FAIL rst_mid_a_out: got %h want 0", {a_valid, a_r, a_g, a_b, a_x, a_y, a_hs}); end
    total++; if ({b_valid, b_r, b_g, b_b, b_x, b_y, b_hs, b_vs} !== 51'd0) begin bad++; $display("FAIL rst_mid_b_out: got %h want 0", {b_valid, b_r, b_g, b_b, b_x, b_y, b_hs, b_vs}); end
    total++; if (a_vs !== 1'b1) begin bad++; $display("FAIL rst_mid_vs: got %b want 1", a_vs); end
    cyc();
    href = 1'b0;
    data = 8'd0;
    repeat (2) cyc();
    rst_n = 1'b1;
    repeat (2) cyc();
    clear_logs();
    drive_frame(2, 8, 8'hF8, 8'h1F, 1'b0);
    total++; if (a_state !== 2'd1) begin bad++; $display("FAIL rst_resume_a_state: got %0d want 1", a_state); end
    total++; if (qa.size() != 0) begin bad++; $display("FAIL rst_resume_a_valid: got %0d want 0", qa.size()); end
    total++; if (b_state !== 2'd2 || qb.size() != 2) begin bad++; $display("FAIL rst_resume_b: got state=%0d n=%0d want 2 2", b_state, qb.size()); end
  endtask

  initial begin
    test_reset();
    test_skip();
    test_crop();
    test_colour();
    test_enable();
    test_odd_bytes();
    test_abort_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
